// File: rtl/mipi_raw10_pkg.sv
// Shared RAW10 definitions: group geometry and the 4-pixel -> 5-byte packing
// function, reused as the reference model by the depacker bench.
package mipi_raw10_pkg;

  localparam int RAW10_PIX_W         = 10;
  localparam int RAW10_PIX_PER_GRP   = 4;
  localparam int RAW10_BYTES_PER_GRP = 5;

  // Input {P3,P2,P1,P0}; output byte0 at [7:0] is the first byte on the wire.
  // Bytes 0..3 are the pixel MSBs, byte 4 gathers the four 2-bit LSB pairs.
  function automatic logic [39:0] raw10_pack_group(input logic [39:0] pix);
    logic [39:0] grp;
    grp = '0;
    for (int p = 0; p < RAW10_PIX_PER_GRP; p++) begin
      grp[8*p +: 8]      = pix[RAW10_PIX_W*p + 2 +: 8];
      grp[32 + 2*p +: 2] = pix[RAW10_PIX_W*p +: 2];
    end
    return grp;
  endfunction

endpackage

// File: rtl/mipi_tx_raw10_packer.sv
// RAW10 transmit packer: 40-bit pixel beats in, 32-bit CSI-2 byte words out.
// An 8-byte staging buffer absorbs the 5-into-4 rate mismatch; the input
// stalls one cycle in five when the buffer is full, and the line end flushes
// a short, padded final word.
module mipi_tx_raw10_packer
  import mipi_raw10_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        data_valid_i,
  input  logic [39:0] data_i,
  input  logic        data_last_i,
  output logic        data_ready_o,
  output logic        output_valid_o,
  output logic [31:0] output_o,
  output logic [2:0]  output_bytes_o,
  output logic        output_last_o
);

  logic [63:0] buf_q, buf_n;
  logic [3:0]  cnt_q, cnt_n;
  logic        flush_q, flush_n;
  logic        ov_n, ol_n;
  logic [31:0] od_n;
  logic [2:0]  ob_n;
  logic        accept;
  logic [39:0] grp;
  logic [5:0]  sh;

  assign data_ready_o = !flush_q && (cnt_q != 4'd8);
  assign accept       = data_valid_i && data_ready_o;
  assign grp          = raw10_pack_group(data_i);

  // Next-state for buffer, count and output word: emit from the current
  // contents first, then append the new group behind whatever remains.
  always_comb begin
    buf_n   = buf_q;
    cnt_n   = cnt_q;
    flush_n = flush_q;
    ov_n    = 1'b0;
    ol_n    = 1'b0;
    od_n    = output_o;
    ob_n    = output_bytes_o;
    sh      = '0;

    if (flush_q && cnt_q <= 4'd4) begin
      // Final word of the line; a count of exactly 4 yields a full last word.
      if (cnt_q != 4'd0) begin
        ov_n = 1'b1;
        ol_n = 1'b1;
        ob_n = cnt_q[2:0];
        for (int i = 0; i < 4; i++) begin
          od_n[8*i +: 8] = (4'(i) < cnt_q) ? buf_q[8*i +: 8] : PAD_BYTE;
        end
      end
      buf_n   = '0;
      cnt_n   = 4'd0;
      flush_n = 1'b0;
    end else if (cnt_q >= 4'd4) begin
      ov_n  = 1'b1;
      ob_n  = 3'd4;
      od_n  = buf_q[31:0];
      buf_n = buf_q >> 32;
      cnt_n = cnt_q - 4'd4;
    end

    if (accept) begin
      // Remaining count is at most 3 here, so the group always fits.
      sh      = {cnt_n[2:0], 3'b000};
      buf_n   = buf_n | ({24'd0, grp} << sh);
      cnt_n   = cnt_n + 4'(RAW10_BYTES_PER_GRP);
      flush_n = data_last_i;
    end
  end

  // State and output registers; reset drops any partially buffered line.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      buf_q          <= '0;
      cnt_q          <= '0;
      flush_q        <= 1'b0;
      output_valid_o <= 1'b0;
      output_o       <= '0;
      output_bytes_o <= '0;
      output_last_o  <= 1'b0;
    end else begin
      buf_q          <= buf_n;
      cnt_q          <= cnt_n;
      flush_q        <= flush_n;
      output_valid_o <= ov_n;
      output_o       <= od_n;
      output_bytes_o <= ob_n;
      output_last_o  <= ol_n;
    end
  end

endmodule

// File: tb/tb_mipi_tx_raw10_packer.sv
// Directed bench for the RAW10 transmit packer using the reference group G
// (P0=048,P1=0D1,P2=15A,P3=1E3 -> bytes 12 34 56 78 E4).
module tb_mipi_tx_raw10_packer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic        data_valid_i;
  logic [39:0] data_i;
  logic        data_last_i;
  logic        data_ready_o;
  logic        output_valid_o;
  logic [31:0] output_o;
  logic [2:0]  output_bytes_o;
  logic        output_last_o;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [39:0] G = {10'h1E3, 10'h15A, 10'h0D1, 10'h048};

  logic [31:0] wq[$];
  logic [2:0]  bq[$];
  logic        lq[$];

  always #5 clk = ~clk;

  mipi_tx_raw10_packer #(.PAD_BYTE(8'h00)) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .data_valid_i   (data_valid_i),
    .data_i         (data_i),
    .data_last_i    (data_last_i),
    .data_ready_o   (data_ready_o),
    .output_valid_o (output_valid_o),
    .output_o       (output_o),
    .output_bytes_o (output_bytes_o),
    .output_last_o  (output_last_o)
  );

  // capture every emitted word mid-cycle
  always @(negedge clk) begin
    if (output_valid_o === 1'b1) begin
      wq.push_back(output_o);
      bq.push_back(output_bytes_o);
      lq.push_back(output_last_o);
    end
  end

  task automatic clear_q();
    wq.delete(); bq.delete(); lq.delete();
  endtask

  task automatic idle(input int n);
    data_valid_i = 1'b0;
    data_last_i  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // present G until accepted; waited = edges until acceptance
  task automatic send_beat(input logic last, output int waited);
    logic acc;
    acc = 1'b0;
    waited = 0;
    data_valid_i = 1'b1;
    data_i = G;
    data_last_i = last;
    while (!acc && waited < 20) begin
      acc = data_ready_o;
      @(posedge clk);
      #1;
      waited++;
    end
    if (!acc) begin
      vectors++; miscompares++;
      $display("FAIL send_beat timeout: ready never high in %0d cycles", waited);
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    data_valid_i = 1'b1;
    data_i = G;
    data_last_i = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      vectors++;
      if (output_valid_o !== 1'b0) begin
        miscompares++; $display("FAIL reset_valid got %b want 0", output_valid_o);
      end
      vectors++;
      if (output_o !== 32'h0) begin
        miscompares++; $display("FAIL reset_data got %h want 00000000", output_o);
      end
    end
    vectors++;
    if (output_bytes_o !== 3'd0 || output_last_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_bytes_last got %0d/%b want 0/0", output_bytes_o, output_last_o);
    end
    reset_i = 1'b0;
    data_valid_i = 1'b0;
    clear_q();
    vectors++;
    if (data_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL reset_ready got %b want 1", data_ready_o);
    end
    idle(4);
    @(negedge clk);
    vectors++;
    if (wq.size() != 0) begin
      miscompares++; $display("FAIL reset_no_words got %0d words want 0", wq.size());
    end
  endtask

  task automatic test_single(input string tag);
    int w;
    logic [31:0] ew [2];
    logic [2:0]  eb [2];
    ew = '{32'h78563412, 32'h000000E4};
    eb = '{3'd4, 3'd1};
    clear_q();
    send_beat(1'b1, w);
    vectors++;
    if (data_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL %s ready_after_accept got %b want 0", tag, data_ready_o);
    end
    @(posedge clk); #1;
    vectors++;
    if (data_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL %s ready_first_word got %b want 0", tag, data_ready_o);
    end
    @(posedge clk); #1;
    vectors++;
    if (data_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL %s ready_after_last got %b want 1", tag, data_ready_o);
    end
    idle(3);
    @(negedge clk);
    vectors++;
    if (wq.size() != 2) begin
      miscompares++; $display("FAIL %s word_count got %0d want 2", tag, wq.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (wq[i] !== ew[i] || bq[i] !== eb[i] || lq[i] !== (i == 1)) begin
          miscompares++;
          $display("FAIL %s word%0d got %h/%0d/%b want %h/%0d/%b", tag, i,
                   wq[i], bq[i], lq[i], ew[i], eb[i], (i == 1));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int w;
    logic [31:0] ew [5];
    ew = '{32'h78563412, 32'h563412E4, 32'h3412E478, 32'h12E47856, 32'hE4785634};
    clear_q();
    for (int b = 0; b < 4; b++) begin
      send_beat(b == 3, w);
      vectors++;
      if (w != 1) begin
        miscompares++; $display("FAIL b2b beat%0d wait got %0d want 1", b, w);
      end
    end
    idle(6);
    @(negedge clk);
    vectors++;
    if (wq.size() != 5) begin
      miscompares++; $display("FAIL b2b word_count got %0d want 5", wq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (wq[i] !== ew[i] || bq[i] !== 3'd4 || lq[i] !== (i == 4)) begin
          miscompares++;
          $display("FAIL b2b word%0d got %h/%0d/%b want %h/4/%b", i,
                   wq[i], bq[i], lq[i], ew[i], (i == 4));
        end
      end
    end
  endtask

  task automatic test_gaps();
    int w;
    logic [31:0] ew [5];
    ew = '{32'h78563412, 32'h563412E4, 32'h3412E478, 32'h12E47856, 32'hE4785634};
    clear_q();
    for (int b = 0; b < 4; b++) begin
      send_beat(b == 3, w);
      if (b < 3) idle(2);
    end
    idle(6);
    @(negedge clk);
    vectors++;
    if (wq.size() != 5) begin
      miscompares++; $display("FAIL gaps word_count got %0d want 5", wq.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        vectors++;
        if (wq[i] !== ew[i] || bq[i] !== 3'd4 || lq[i] !== (i == 4)) begin
          miscompares++;
          $display("FAIL gaps word%0d got %h/%0d/%b want %h/4/%b", i,
                   wq[i], bq[i], lq[i], ew[i], (i == 4));
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    int w;
    clear_q();
    for (int b = 0; b < 3; b++) send_beat(1'b0, w);
    // seven bytes buffered now
    reset_i = 1'b1;
    data_valid_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    vectors++;
    if (data_ready_o !== 1'b1) begin
      miscompares++; $display("FAIL midreset ready got %b want 1", data_ready_o);
    end
    idle(5);
    @(negedge clk);
    vectors++;
    if (wq.size() != 2) begin
      miscompares++; $display("FAIL midreset word_count got %0d want 2", wq.size());
    end
    @(posedge clk); #1;
    test_single("after_reset");
  endtask

  task automatic test_hold_valid();
    int w1, w2, nlast;
    logic [31:0] ew [4];
    ew = '{32'h78563412, 32'h000000E4, 32'h78563412, 32'h000000E4};
    clear_q();
    send_beat(1'b1, w1);
    vectors++;
    if (data_ready_o !== 1'b0) begin
      miscompares++; $display("FAIL hold ready_during_flush got %b want 0", data_ready_o);
    end
    send_beat(1'b1, w2);
    vectors++;
    if (w2 != 3) begin
      miscompares++; $display("FAIL hold second_accept_wait got %0d want 3", w2);
    end
    idle(6);
    @(negedge clk);
    vectors++;
    if (wq.size() != 4) begin
      miscompares++; $display("FAIL hold word_count got %0d want 4", wq.size());
    end else begin
      nlast = 0;
      for (int i = 0; i < 4; i++) begin
        if (lq[i] === 1'b1) nlast++;
        vectors++;
        if (wq[i] !== ew[i]) begin
          miscompares++; $display("FAIL hold word%0d got %h want %h", i, wq[i], ew[i]);
        end
      end
      vectors++;
      if (nlast != 2 || lq[1] !== 1'b1 || lq[3] !== 1'b1) begin
        miscompares++; $display("FAIL hold last_flags got %0d lasts want 2 at words 1,3", nlast);
      end
    end
  endtask

  initial begin
    reset_i = 1'b1;
    data_valid_i = 1'b0;
    data_i = '0;
    data_last_i = 1'b0;
    #1;
    test_reset();
    test_single("single");
    test_back_to_back();
    test_gaps();
    test_reset_midline();
    test_hold_valid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
